// File: rtl/inst_mem_loader.sv
// inst_mem_loader
//   Packs a valid/ready byte stream into 32-bit words, big-end first, so that
//   the instruction ROM read-side byte swap yields the original little-endian
//   instruction. Writes the words to consecutive word-aligned byte addresses.
//   One load runs per i_start pulse.
//
// Configuration macro: INST_MEM_LOADER_CLEAR_EN
//   defined   - after the load, words N .. 2^ADDR_WIDTH-1 are zero-filled
//   undefined - unloaded locations are left untouched
//
// Ports
//   i_clock, i_reset   rising-edge clock, async active-high reset
//   i_start            load request, honoured in IDLE/DONE only
//   i_num_words        words to load (clamped to 2^ADDR_WIDTH), sampled on start
//   i_byte_valid/data  byte source
//   o_byte_ready       byte accepted this cycle (decoded from state)
//   o_wr_en/addr/data  one-cycle memory write
//   o_word_count       data words written in the current load
//   o_busy, o_done     status
//
// state   | meaning
// S_IDLE  | waiting for first start
// S_LOAD  | accepting bytes of the current word
// S_WRITE | issuing the write of the packed word
// S_CLEAR | zero-filling unloaded words (macro only)
// S_DONE  | load finished, waiting for next start
module inst_mem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_num_words,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  output logic                  o_wr_en,
  output logic [31:0]           o_wr_addr,
  output logic [31:0]           o_wr_data,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH:0] W_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
`ifdef INST_MEM_LOADER_CLEAR_EN
  localparam logic [ADDR_WIDTH:0] W_LAST  = {1'b0, {ADDR_WIDTH{1'b1}}};
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
`ifdef INST_MEM_LOADER_CLEAR_EN
    , S_CLEAR = 3'd4
`endif
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_WIDTH:0] r_n, w_n_nxt;
  logic [1:0]          r_byte_idx, w_byte_idx_nxt;
  logic [31:0]         r_pack, w_pack_nxt;
  logic [ADDR_WIDTH:0] r_word_idx, w_word_idx_nxt;
  logic [ADDR_WIDTH:0] r_count, w_count_nxt;
  logic                w_wr_en_nxt;
  logic [31:0]         w_wr_addr_nxt;
  logic [31:0]         w_wr_data_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic [ADDR_WIDTH:0] w_n_clamp;
  logic [ADDR_WIDTH:0] w_count_inc;

  assign w_n_clamp    = i_num_words[ADDR_WIDTH] ? W_DEPTH : i_num_words;
  assign w_count_inc  = r_count + 1'b1;
  assign o_byte_ready = (r_state == S_LOAD);

  always_comb begin
    w_state_nxt    = r_state;
    w_n_nxt        = r_n;
    w_byte_idx_nxt = r_byte_idx;
    w_pack_nxt     = r_pack;
    w_word_idx_nxt = r_word_idx;
    w_count_nxt    = r_count;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_n_nxt        = w_n_clamp;
          w_byte_idx_nxt = 2'd0;
          w_pack_nxt     = 32'd0;
          w_word_idx_nxt = '0;
          w_count_nxt    = '0;
          if (w_n_clamp == '0) begin
`ifdef INST_MEM_LOADER_CLEAR_EN
            w_state_nxt = S_CLEAR;
`else
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (i_byte_valid) begin
          // shift-in places the first byte of the word in [31:24]
          w_pack_nxt = {r_pack[23:0], i_byte_data};
          if (r_byte_idx == 2'd3) begin
            w_byte_idx_nxt = 2'd0;
            w_state_nxt    = S_WRITE;
          end else begin
            w_byte_idx_nxt = r_byte_idx + 2'd1;
          end
        end
      end
      S_WRITE: begin
        w_count_nxt    = w_count_inc;
        w_word_idx_nxt = r_word_idx + 1'b1;
        if (w_count_inc == r_n) begin
`ifdef INST_MEM_LOADER_CLEAR_EN
          w_state_nxt = (r_n == W_DEPTH) ? S_DONE : S_CLEAR;
`else
          w_state_nxt = S_DONE;
`endif
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
`ifdef INST_MEM_LOADER_CLEAR_EN
      S_CLEAR: begin
        w_word_idx_nxt = r_word_idx + 1'b1;
        if (r_word_idx == W_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so that they line up
  // with the state they describe.
  always_comb begin
    w_wr_en_nxt = (w_state_nxt == S_WRITE);
`ifdef INST_MEM_LOADER_CLEAR_EN
    if (w_state_nxt == S_CLEAR) begin
      w_wr_en_nxt = 1'b1;
    end
`endif
    w_wr_addr_nxt = 32'd0;
    if (w_wr_en_nxt) begin
      w_wr_addr_nxt = {{(32 - ADDR_WIDTH - 3){1'b0}}, w_word_idx_nxt, 2'b00};
    end
    w_wr_data_nxt = (w_state_nxt == S_WRITE) ? w_pack_nxt : 32'd0;
    w_busy_nxt    = (w_state_nxt == S_LOAD) || (w_state_nxt == S_WRITE);
`ifdef INST_MEM_LOADER_CLEAR_EN
    if (w_state_nxt == S_CLEAR) begin
      w_busy_nxt = 1'b1;
    end
`endif
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_byte_idx   <= 2'd0;
      r_pack       <= 32'd0;
      r_word_idx   <= '0;
      r_count      <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= 32'd0;
      o_wr_data    <= 32'd0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_n          <= w_n_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_pack       <= w_pack_nxt;
      r_word_idx   <= w_word_idx_nxt;
      r_count      <= w_count_nxt;
      o_wr_en      <= w_wr_en_nxt;
      o_wr_addr    <= w_wr_addr_nxt;
      o_wr_data    <= w_wr_data_nxt;
      o_busy       <= w_busy_nxt;
      o_done       <= w_done_nxt;
    end
  end

  assign o_word_count = r_count;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: expected writes are built from the byte stream
// (arithmetic packing) and from the clamp/zero-fill rules, queued, and checked
// by one monitor on every falling edge.
module tb_inst_mem_loader;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [AW:0]   i_num_words;
  logic          i_byte_valid;
  logic [7:0]    i_byte_data;
  logic          o_byte_ready;
  logic          o_wr_en;
  logic [31:0]   o_wr_addr;
  logic [31:0]   o_wr_data;
  logic [AW:0]   o_word_count;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  inst_mem_loader #(.ADDR_WIDTH(AW)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(i_start), .i_num_words(i_num_words),
    .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data),
    .o_byte_ready(o_byte_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_word_count(o_word_count), .o_busy(o_busy),
    .o_done(o_done)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          is_data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        pend_q[$];
  wr_t        mon_e;
  logic [7:0] src_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         seen     = 0;
  int         cur_n    = 0;
  bit         mon_en   = 1'b0;
  bit         done_due = 1'b0;
`ifdef INST_MEM_LOADER_CLEAR_EN
  bit         clear_en = 1'b1;
`else
  bit         clear_en = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic wr_t mk(input int addr, input logic [31:0] data, input bit is_data);
    wr_t e;
    e.addr = 32'(addr);
    e.data = data;
    e.is_data = is_data;
    return e;
  endfunction

  function automatic void push_clear(input int n);
    if (clear_en) begin
      for (int i = n; i < DEPTH; i++) pend_q.push_back(mk(i * 4, 32'd0, 1'b0));
    end
  endfunction

  // model: byte 4w+k lands in the word at weight 256^(3-k)
  function automatic void push_model(input int nw);
    int n;
    logic [31:0] d;
    n = (nw > DEPTH) ? DEPTH : nw;
    for (int w = 0; w < n; w++) begin
      d = 32'(src_q[4*w]) * 32'h0100_0000 + 32'(src_q[4*w+1]) * 32'h0001_0000
        + 32'(src_q[4*w+2]) * 32'h0000_0100 + 32'(src_q[4*w+3]);
      pend_q.push_back(mk(w * 4, d, 1'b1));
    end
    push_clear(n);
  endfunction

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (done_due) begin
        chk("done_after_last_write", o_done, 1);
        chk("busy_after_last_write", o_busy, 0);
        done_due = 1'b0;
      end else if (exp_q.size() != 0) begin
        chk("busy_during_load", o_busy, 1);
        chk("done_during_load", o_done, 0);
      end
      chk("word_count", o_word_count, seen);
      if (o_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wr_en", o_wr_en, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", o_wr_addr, mon_e.addr);
          chk("wr_data", o_wr_data, mon_e.data);
          if (mon_e.is_data) seen++;
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end
    end
  end

  task automatic do_start(input int nw);
    bit zero_done;
    i_num_words = nw[AW:0];
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_num_words = AW'($urandom);
    seen = 0;
    cur_n = (nw > DEPTH) ? DEPTH : nw;
    while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
    zero_done = (cur_n == 0) && !clear_en;
    @(negedge clk);
    if (zero_done) begin
      chk("zero_len_done", o_done, 1);
      chk("zero_len_busy", o_busy, 0);
    end else begin
      chk("ready_after_start", o_byte_ready, (cur_n != 0) ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int stall_idx, input int stall_len, input bit rnd, input int start_k);
    int k = 0;
    int guard = 0;
    int stalled = 0;
    bit v;
    bit rdy;
    bit pulsed = 1'b0;
    while (k < src_q.size()) begin
      guard++;
      if (guard > 2000) begin
        chk("feed_timeout", k, src_q.size());
        break;
      end
      v = 1'b1;
      if (k == stall_idx && stalled < stall_len) begin
        v = 1'b0;
        stalled++;
      end else if (rnd && $urandom_range(0, 3) == 0) begin
        v = 1'b0;
      end
      i_byte_valid = v;
      i_byte_data  = v ? src_q[k] : 8'($urandom);
      if (k == start_k && !pulsed) begin
        i_start = 1'b1;
        i_num_words = AW'($urandom_range(0, DEPTH));
        pulsed = 1'b1;
      end
      @(negedge clk);
      rdy = o_byte_ready;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      if (v && rdy) k++;
    end
    i_byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (o_done) break;
    end
    chk("done_reached", o_done, 1);
    chk("all_writes_seen", exp_q.size(), 0);
    chk("final_word_count", o_word_count, cur_n);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_byte_ready", o_byte_ready, 0);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_wr_addr", o_wr_addr, 0);
    chk("rst_wr_data", o_wr_data, 0);
    chk("rst_word_count", o_word_count, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
  endtask

  initial begin
    int nw;
    rst = 1'b1;
    i_start = 1'b0;
    i_num_words = '0;
    i_byte_valid = 1'b0;
    i_byte_data = 8'd0;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // single word, valid held high
    src_q = '{8'h00, 8'h40, 8'h0A, 8'h20};
    pend_q.push_back(mk(0, 32'h00400A20, 1'b1));
    push_clear(1);
    do_start(1);
    feed(-1, 0, 1'b0, -1);
    wait_done();

    // two words, three idle cycles before the third byte
    src_q = '{8'h01, 8'h4A, 8'h50, 8'h20, 8'hAD, 8'h4B, 8'h00, 8'h00};
    pend_q.push_back(mk(0, 32'h014A5020, 1'b1));
    pend_q.push_back(mk(4, 32'hAD4B0000, 1'b1));
    push_clear(2);
    do_start(2);
    feed(2, 3, 1'b0, -1);
    wait_done();

    // zero length
    src_q.delete();
    push_clear(0);
    do_start(0);
    wait_done();

    // three words
    src_q.delete();
    for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom));
    push_model(3);
    do_start(3);
    feed(-1, 0, 1'b0, -1);
    wait_done();

    // reset after two bytes of the first word
    src_q = '{8'h11, 8'h22};
    do_start(1);
    feed(-1, 0, 1'b0, -1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    seen = 0;
    done_due = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    pend_q.push_back(mk(0, 32'hA1B2C3D4, 1'b1));
    push_clear(1);
    do_start(1);
    feed(-1, 0, 1'b0, -1);
    wait_done();

    // start pulse during load is ignored
    src_q.delete();
    for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom));
    push_model(3);
    do_start(3);
    feed(-1, 0, 1'b1, 6);
    wait_done();

    // oversize request clamps to full depth
    src_q.delete();
    for (int i = 0; i < 4 * DEPTH; i++) src_q.push_back(8'($urandom));
    push_model(DEPTH + 1);
    do_start(DEPTH + 1);
    feed(-1, 0, 1'b1, -1);
    wait_done();

    // random loads
    for (int r = 0; r < 8; r++) begin
      nw = $urandom_range(0, DEPTH + 1);
      src_q.delete();
      for (int i = 0; i < 4 * ((nw > DEPTH) ? DEPTH : nw); i++) src_q.push_back(8'($urandom));
      push_model(nw);
      do_start(nw);
      feed(-1, 0, 1'b1, -1);
      wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Sequential write-side companion to the instruction ROM. Accepts a byte stream over a valid/ready handshake, packs every four bytes into one 32-bit word in the instruction memory's storage byte order, and issues single-cycle word writes at consecutive word-aligned byte addresses. It sits between a host byte source (UART receiver or testbench driver) and the write port of the instruction memory. It runs once per `start` pulse.

## Interface
- `ADDR_WIDTH`, default 10: log2 of memory depth in 32-bit words.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `num_words`  in  ADDR_WIDTH+1  number of words to load; sampled on `start`.
- `byte_valid`  in  1  the source presents `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  the loader accepts a byte this cycle.
- `wr_en`  out  1  one-cycle memory write strobe.
- `wr_addr`  out  32  byte address of the write; always word-aligned, so bits [1:0] = 0.
- `wr_data`  out  32  packed word.
- `word_count`  out  ADDR_WIDTH+1  number of words of the current load written so far.
- `busy`  out  1  high in LOAD, WRITE and CLEAR.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, LOAD, WRITE, CLEAR (present only with the macro), DONE.
- **IDLE/DONE + `start`:**
  - Latch `N` = min(`num_words`, 2^ADDR_WIDTH).
  - Clear `word_count`, the byte index and the word index.
  - If `N` = 0, go to DONE, or to CLEAR when the macro is defined. Otherwise go to LOAD.
- **LOAD:**
  - `byte_ready` = 1.
  - A byte is accepted on a rising edge where `byte_valid` and `byte_ready` are both high.
  - Byte k of the word (k = 0..3) is placed in bits [31-8k:24-8k]. The first byte goes to [31:24] and the fourth to [7:0].
  - This byte order matches the ROM storage format, so the read-side byte swap yields the original little-endian instruction.
  - Acceptance of byte 3 moves the FSM to WRITE.
- **WRITE:**
  - `byte_ready` = 0.
  - `wr_en` = 1 for exactly one cycle, with `wr_addr` = word_index × 4 and `wr_data` = the packed word.
  - On exit, `word_count` and the word index increment.
  - If the new `word_count` = `N`, go to DONE (or CLEAR). Otherwise go back to LOAD.
- **CLEAR:**
  - Writes 0x00000000 one word per cycle (`wr_en` = 1) at word indices `N` .. 2^ADDR_WIDTH−1.
  - After the last index, go to DONE. If `N` = 2^ADDR_WIDTH, CLEAR is skipped.
- **DONE:** `done` = 1. The state is held until the next `start`.
- `start` while `busy` is ignored.
- Bytes arriving with `byte_valid` high outside LOAD are not accepted; `byte_ready` = 0 there.
- Word index arithmetic is ADDR_WIDTH+1 bits. `wr_addr` is zero-extended word_index << 2.

## Timing
- Reset values:
  - State = IDLE.
  - `byte_ready` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `word_count` = 0, `busy` = 0, `done` = 0.
  - Byte index = 0 and the packing register = 0.
- All outputs are registered except `byte_ready`, which is decoded from state.
- `start` at edge t puts the FSM in LOAD at t+1, with `byte_ready` high at t+1.
- The 4th byte accepted at edge t gives `wr_en` high during cycle t+1. LOAD resumes at t+2.
- Peak throughput is 4 bytes per 5 cycles.
- The source may drop `byte_valid` at any point. Bytes already accepted are retained, and assembly resumes with the next accepted byte.
- Reset asserted mid-load:
  - All state returns to reset values immediately (asynchronous).
  - A partially assembled word is discarded and not written.
  - Memory contents already written are unaffected.
- `done` falls and `busy` rises in the cycle after a new `start` edge.

## Configuration
- Macro `INST_MEM_LOADER_CLEAR_EN`.
  - **Defined:** the CLEAR state exists, and words `N` .. 2^ADDR_WIDTH−1 are zero-filled after the load. This matches the ROM zero-initialisation of unused locations.
  - **Undefined:** there is no CLEAR state. The FSM goes straight to DONE after the last word (or on `N` = 0), and unloaded locations keep their prior contents.

## Test plan
- **Single word:** `num_words` = 1, bytes 0x00, 0x40, 0x0A, 0x20 with `byte_valid` held high. Exactly one `wr_en` pulse with `wr_addr` = 0x0 and `wr_data` = 0x00400A20. `done` rises 1 cycle later (macro undefined).
- **Two words with stalls:** `num_words` = 2, bytes 01 4A 50 20 AD 4B 00 00, with `byte_valid` low for 3 cycles between bytes 2 and 3.
  - Writes 0x014A5020 @0x0 and 0xAD4B0000 @0x4.
  - `word_count` reads 1, then 2.
  - No byte is accepted while `byte_valid` is low.
- **Zero length:** `num_words` = 0. DONE on the next cycle with no `wr_en` (macro undefined). With the macro and ADDR_WIDTH = 4: 16 zero writes @0x0..0x3C, then DONE.
- **Clear fill (macro, ADDR_WIDTH = 4):** `num_words` = 3. Three data writes @0x0, 0x4, 0x8, then 13 zero writes @0xC..0x3C on consecutive cycles, then `done` = 1.
- **Reset mid-word:** assert `reset` after 2 bytes of word 1.
  - All outputs read 0 and the state is IDLE.
  - A new `start` with `num_words` = 1 and 4 fresh bytes writes @0x0 with only the fresh bytes.
- **Start while busy / overflow clamp:**
  - A `start` pulse during LOAD is ignored, and `word_count` continues.
  - `num_words` = 2^ADDR_WIDTH+1 (ADDR_WIDTH = 2) clamps to 4 writes @0x0..0xC, then DONE.
